sma_sequencer: RTL and testbench

- Controls the SMA datapath.
- Accepts input samples over a valid/ready handshake and issues one shift pulse per sample to the sliding-window shift buffer (data_buffer).
- Reads the buffer's packed window and serially sums it with a single shared adder, BUFFER_SIZE cycles per sample.
- Emits the truncated mean over a valid/ready output handshake.
- Sits between the sample source and the averaged-output consumer in the sma_calc top level.

---
 rtl/sma_pkg.sv | 23 ++
 rtl/sma_serial_accum.sv | 46 ++++
 rtl/sma_sequencer.sv | 114 +++++++++++
 tb/tb_sma_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sma_pkg.sv
// rtl/sma_pkg.sv - shared defaults, state encoding and constant helpers for the SMA datapath
package sma_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_BUFFER_SIZE = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  // Ceiling log2 for sizing; exact for the power-of-two window lengths used here
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sma_serial_accum.sv
// rtl/sma_serial_accum.sv - serial window summer with one shared adder and shift divide
module sma_serial_accum
  import sma_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BUFFER_SIZE = DEF_BUFFER_SIZE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [DATA_WIDTH*BUFFER_SIZE-1:0] window,
  output logic                              done,
  output logic [DATA_WIDTH-1:0]             result
);

  localparam int LOG_N = clog2(BUFFER_SIZE);
  localparam int AW    = DATA_WIDTH + LOG_N;

  logic [AW-1:0]         acc_q, acc_d;
  logic [LOG_N-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word;
  logic [AW-1:0]         sum;

  // start is held high for every accumulate cycle; acc/idx sit at zero otherwise,
  // so the first accumulate cycle always begins from a clean sum
  always_comb begin
    word   = window[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    sum    = acc_q + {{LOG_N{1'b0}}, word};
    done   = start && (idx_q == LOG_N'(BUFFER_SIZE - 1));
    result = sum[AW-1:LOG_N];
    acc_d  = start ? sum : '0;
    idx_d  = start ? idx_q + 1'b1 : '0;
  end

  // accumulator and word index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/sma_sequencer.sv
// rtl/sma_sequencer.sv - sample handshake, fill count and output control for the SMA datapath
module sma_sequencer
  import sma_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BUFFER_SIZE = DEF_BUFFER_SIZE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [DATA_WIDTH-1:0]             s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic                              buf_shift,
  output logic [DATA_WIDTH-1:0]             buf_data,
  input  logic [DATA_WIDTH*BUFFER_SIZE-1:0] buf_window,
  output logic [DATA_WIDTH-1:0]             m_avg,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              window_full,
  output logic                              busy
);

  localparam int CW = clog2(BUFFER_SIZE) + 1;

  state_t                state_q, state_d;
  logic [CW-1:0]         fill_q, fill_d;
  logic [DATA_WIDTH-1:0] m_avg_q, m_avg_d;
  logic                  m_valid_q, m_valid_d;
  logic                  window_full_q, window_full_d;
  logic                  accept;
  logic                  acc_done;
  logic [DATA_WIDTH-1:0] acc_result;

  // the buffer shifts on the same edge as the input handshake
  assign s_ready     = (state_q == IDLE) && !flush;
  assign accept      = s_valid && s_ready;
  assign buf_shift   = accept && !rst;
  assign buf_data    = s_data;
  assign m_avg       = m_avg_q;
  assign m_valid     = m_valid_q;
  assign window_full = window_full_q;
  assign busy        = (state_q != IDLE);

  sma_serial_accum #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUFFER_SIZE(BUFFER_SIZE)
  ) u_accum (
    .clk   (clk),
    .rst   (rst),
    .start (state_q == ACCUM),
    .window(buf_window),
    .done  (acc_done),
    .result(acc_result)
  );

  // next-state logic; flush overrides everything and discards any in-flight result
  always_comb begin
    state_d       = state_q;
    fill_d        = fill_q;
    m_avg_d       = m_avg_q;
    m_valid_d     = m_valid_q;
    window_full_d = window_full_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          fill_d = (fill_q == CW'(BUFFER_SIZE)) ? fill_q : fill_q + 1'b1;
          if (fill_d == CW'(BUFFER_SIZE)) begin
            state_d       = ACCUM;
            window_full_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (acc_done) begin
          m_avg_d   = acc_result;
          m_valid_d = 1'b1;
          state_d   = OUTPUT;
        end
      end
      OUTPUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d       = IDLE;
      fill_d        = '0;
      m_valid_d     = 1'b0;
      window_full_d = 1'b0;
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      fill_q        <= '0;
      m_avg_q       <= '0;
      m_valid_q     <= 1'b0;
      window_full_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_q        <= fill_d;
      m_avg_q       <= m_avg_d;
      m_valid_q     <= m_valid_d;
      window_full_q <= window_full_d;
    end
  end

endmodule

// File: tb/tb_sma_sequencer.sv
// tb/tb_sma_sequencer.sv - directed self-checking bench for sma_sequencer with a shift-buffer model
module tb_sma_sequencer;

  localparam int DW = 8;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          buf_shift;
  logic [DW-1:0] buf_data;
  logic [DW*N-1:0] win = '0;
  logic [DW-1:0] m_avg;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          window_full;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // registered shift buffer: word 0 (low bits) is the newest sample
  always_ff @(posedge clk) begin
    if (buf_shift) win <= {win[DW*(N-1)-1:0], buf_data};
  end

  sma_sequencer #(.DATA_WIDTH(DW), .BUFFER_SIZE(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .buf_shift  (buf_shift),
    .buf_data   (buf_data),
    .buf_window (win),
    .m_avg      (m_avg),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .window_full(window_full),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one input handshake; then either expect a result 5 cycles later or expect silence
  task automatic send(input string tag, input logic [7:0] v, input bit want, input logic [7:0] exp_avg);
    int  n;
    int  lat;
    bit  seen;
    @(negedge clk);
    s_data  = v;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, 32'(s_ready), 1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    lat = 1;
    if (want) begin
      while (!m_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check({tag, "_latency"}, lat, 5);
      check({tag, "_avg"}, 32'(m_avg), 32'(exp_avg));
    end else begin
      seen = 1'b0;
      repeat (6) begin
        if (m_valid) seen = 1'b1;
        @(negedge clk);
      end
      check({tag, "_no_out"}, 32'(seen), 0);
      check({tag, "_idle"}, 32'(busy), 0);
    end
  endtask

  // one flush cycle in IDLE with a sample offered; it must not be taken
  task automatic do_flush(input string tag);
    @(negedge clk);
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'd99;
    #1;
    check({tag, "_flush_s_ready"}, 32'(s_ready), 0);
    check({tag, "_flush_shift"}, 32'(buf_shift), 0);
    @(negedge clk);
    flush   = 1'b0;
    s_valid = 1'b0;
    check({tag, "_flush_wfull"}, 32'(window_full), 0);
  endtask

  initial begin
    bit shifted;
    // reset state
    #12;
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wfull", 32'(window_full), 0);
    check("rst_m_avg", 32'(m_avg), 0);
    check("rst_s_ready", 32'(s_ready), 1);
    check("rst_shift_gated", 32'(buf_shift), 0);
    @(negedge clk);
    rst = 1'b0;

    // warm-up
    send("w10", 8'd10, 1'b0, 8'd0);
    send("w20", 8'd20, 1'b0, 8'd0);
    send("w30", 8'd30, 1'b0, 8'd0);
    check("warm_wfull0", 32'(window_full), 0);
    send("w40", 8'd40, 1'b1, 8'd25);
    check("warm_wfull1", 32'(window_full), 1);

    // sliding window
    send("s50", 8'd50, 1'b1, 8'd35);
    send("s60", 8'd60, 1'b1, 8'd45);

    // truncation
    do_flush("t");
    send("t1a", 8'd1, 1'b0, 8'd0);
    send("t2a", 8'd2, 1'b0, 8'd0);
    send("t2b", 8'd2, 1'b0, 8'd0);
    send("t2c", 8'd2, 1'b1, 8'd1);

    // full-scale, no wrap
    do_flush("f");
    send("f1", 8'd255, 1'b0, 8'd0);
    send("f2", 8'd255, 1'b0, 8'd0);
    send("f3", 8'd255, 1'b0, 8'd0);
    send("f4", 8'd255, 1'b1, 8'd255);

    // backpressure: 255,255,255,7 -> 193
    @(negedge clk);
    m_ready = 1'b0;
    send("bp", 8'd7, 1'b1, 8'd193);
    s_valid = 1'b1;
    s_data  = 8'd77;
    shifted = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (buf_shift) shifted = 1'b1;
      check("bp_m_valid", 32'(m_valid), 1);
      check("bp_m_avg", 32'(m_avg), 193);
      check("bp_s_ready", 32'(s_ready), 0);
    end
    check("bp_no_shift", 32'(shifted), 0);
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_release_m_valid", 32'(m_valid), 0);
    check("bp_release_s_ready", 32'(s_ready), 1);

    // flush during the second accumulate cycle
    @(negedge clk);
    s_data  = 8'd3;
    s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    check("fa_busy_acc", 32'(busy), 1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fa_busy", 32'(busy), 0);
    check("fa_wfull", 32'(window_full), 0);
    shifted = 1'b0;
    repeat (6) begin
      if (m_valid) shifted = 1'b1;
      @(negedge clk);
    end
    check("fa_no_out", 32'(shifted), 0);
    send("fa100", 8'd100, 1'b0, 8'd0);
    send("fa120", 8'd120, 1'b0, 8'd0);
    send("fa140", 8'd140, 1'b0, 8'd0);
    send("fa161", 8'd161, 1'b1, 8'd130);

    // reset while a result is waiting: 120,140,161,200 -> 155
    @(negedge clk);
    m_ready = 1'b0;
    send("ro", 8'd200, 1'b1, 8'd155);
    #2;
    rst = 1'b1;
    #1;
    check("ro_m_valid", 32'(m_valid), 0);
    check("ro_busy", 32'(busy), 0);
    check("ro_wfull", 32'(window_full), 0);
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    send("r8", 8'd8, 1'b0, 8'd0);
    send("r9", 8'd9, 1'b0, 8'd0);
    send("r10", 8'd10, 1'b0, 8'd0);
    send("r13", 8'd13, 1'b1, 8'd10);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
